// File: rtl/rx_eyeq_pkg.sv
// Shared types and step-list helpers for the RX EyeQ sequencer.
// Each sequence selector maps to a fixed, ordered list of eye-equalization modes.
package rx_eyeq_pkg;

  typedef enum logic [3:0] {
    EQ_NONE       = 4'd0,
    EQ_ENRZ_PH1   = 4'd1,
    EQ_ENRZ_PH2   = 4'd2,
    EQ_NRZ_BR     = 4'd3,
    EQ_NRZ_DDR    = 4'd4,
    EQ_NRZ_DDR_CR = 4'd5,
    EQ_NRZ_DDR_EQ = 4'd6
  } eyeqmode_t;

  typedef enum logic [1:0] {
    PD_NORMAL = 2'd0,
    PD_P1     = 2'd1,
    PD_P2     = 2'd2,
    PD_COMA   = 2'd3
  } powerdown_t;

  typedef enum logic [1:0] {
    ERR_NONE        = 2'd0,
    ERR_ILLEGAL_SEL = 2'd1,
    ERR_PDWN        = 2'd2,
    ERR_TIMEOUT     = 2'd3
  } err_code_t;

  typedef enum logic [1:0] {
    SEL_ENRZ    = 2'd0,
    SEL_NRZ_BR  = 2'd1,
    SEL_NRZ_DDR = 2'd2,
    SEL_ILLEGAL = 2'd3
  } seq_sel_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHK_PD = 3'd1,
    S_REQ    = 3'd2,
    S_CAPT   = 3'd3,
    S_DROP   = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  function automatic eyeqmode_t seq_step(input seq_sel_t sel, input logic [1:0] idx);
    eyeqmode_t m;
    m = EQ_NONE;
    case (sel)
      SEL_ENRZ:   m = (idx == 2'd0) ? EQ_ENRZ_PH1 : EQ_ENRZ_PH2;
      SEL_NRZ_BR: m = EQ_NRZ_BR;
      SEL_NRZ_DDR: begin
        case (idx)
          2'd0:    m = EQ_NRZ_DDR;
          2'd1:    m = EQ_NRZ_DDR_CR;
          default: m = EQ_NRZ_DDR_EQ;
        endcase
      end
      default: m = EQ_NONE;
    endcase
    return m;
  endfunction

  function automatic logic [1:0] seq_len(input seq_sel_t sel);
    logic [1:0] n;
    case (sel)
      SEL_ENRZ:    n = 2'd2;
      SEL_NRZ_BR:  n = 2'd1;
      SEL_NRZ_DDR: n = 2'd3;
      default:     n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rx_eyeq_timeout.sv
// Per-phase cycle counter: cleared by load, counts while enabled, saturates at LIMIT.
// expire is a single-cycle strobe on the cycle the count reaches LIMIT.
module rx_eyeq_timeout #(
  parameter int W     = 16,
  parameter int LIMIT = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam logic [W-1:0] LIM  = W'(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != LIM)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Saturation at LIM guarantees the strobe fires at most once per phase.
  assign expire = en && !load && (cnt_q == LAST);

endmodule

// File: rtl/rx_eyeq_seq.sv
// RX EyeQ sequencer: walks the per-selector mode list, running one 4-way
// req/done handshake per step and capturing the PHY result for each.
module rx_eyeq_seq
  import rx_eyeq_pkg::*;
#(
  parameter int RESULT_W    = 32,
  parameter int TIMEOUT_W   = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [1:0]          seq_sel_i,
  input  logic                abort_i,
  input  logic [1:0]          rxpdwn_i,
  input  logic                rxeyeqdone_i,
  input  logic [RESULT_W-1:0] rxeyeq_i,
  output logic                rxeyeqreq_o,
  output logic [3:0]          rxeyeqmode_o,
  output logic                busy_o,
  output logic [1:0]          step_o,
  output logic [RESULT_W-1:0] result_o,
  output logic                result_vld_o,
  output logic                done_o,
  output logic                err_o,
  output logic [1:0]          err_code_o,
  output state_t              state_o
);

  // Handshake: req rises only with pdwn NORMAL and done low; req falls only
  // while done is high; mode is frozen from CHK_PD until done falls in DROP.

  state_t              state_q, state_d;
  seq_sel_t            sel_q;
  logic [1:0]          step_q;
  logic                abort_q;
  logic                pd_flag_q;
  eyeqmode_t           mode_q;
  err_code_t           err_code_q;
  logic [RESULT_W-1:0] result_q;
  logic                result_vld_q, done_q, err_q;

  logic start_ok, start_bad, last_step, abort_any, pd_bad;
  logic tmo_load, tmo_en, tmo_expire;

  assign start_ok  = (state_q == S_IDLE) && start_i && (seq_sel_i != SEL_ILLEGAL);
  assign start_bad = (state_q == S_IDLE) && start_i && (seq_sel_i == SEL_ILLEGAL);
  assign last_step = (step_q == (seq_len(sel_q) - 2'd1));
  assign abort_any = abort_q | abort_i;
  assign pd_bad    = (state_q inside {S_REQ, S_CAPT}) && (rxpdwn_i != PD_NORMAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_ok) state_d = S_CHK_PD;
      S_CHK_PD: begin
        if (abort_any)                                        state_d = S_FIN;
        else if ((rxpdwn_i == PD_NORMAL) && !rxeyeqdone_i) state_d = S_REQ;
      end
      S_REQ:    if (rxeyeqdone_i) state_d = S_CAPT;
      S_CAPT:   state_d = S_DROP;
      S_DROP:   if (!rxeyeqdone_i) state_d = (abort_any || last_step) ? S_FIN : S_CHK_PD;
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign tmo_load = (state_d != state_q);
  assign tmo_en   = (state_q == S_REQ) || (state_q == S_DROP);

  rx_eyeq_timeout #(
    .W     (TIMEOUT_W),
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .load   (tmo_load),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q        <= SEL_ENRZ;
      step_q       <= 2'd0;
      abort_q      <= 1'b0;
      pd_flag_q    <= 1'b0;
      mode_q       <= EQ_NONE;
      err_code_q   <= ERR_NONE;
      result_q     <= '0;
      result_vld_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      result_vld_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;

      if (start_bad) begin
        err_q      <= 1'b1;
        done_q     <= 1'b1;
        err_code_q <= ERR_ILLEGAL_SEL;
      end

      // A start coinciding with abort still launches; the abort is kept.
      if (start_ok) begin
        sel_q      <= seq_sel_t'(seq_sel_i);
        step_q     <= 2'd0;
        abort_q    <= abort_i;
        err_code_q <= ERR_NONE;
        mode_q     <= seq_step(seq_sel_t'(seq_sel_i), 2'd0);
      end

      if ((state_q != S_IDLE) && (state_q != S_FIN) && abort_i) abort_q <= 1'b1;

      if (state_q == S_CHK_PD) pd_flag_q <= 1'b0;
      if (pd_bad && !pd_flag_q) begin
        pd_flag_q  <= 1'b1;
        err_q      <= 1'b1;
        err_code_q <= ERR_PDWN;
      end

      if (tmo_expire) begin
        err_q      <= 1'b1;
        err_code_q <= ERR_TIMEOUT;
      end

      if ((state_q == S_CAPT) && !abort_any) begin
        result_q     <= rxeyeq_i;
        result_vld_q <= 1'b1;
      end

      // Next mode is loaded only once done has fallen.
      if ((state_q == S_DROP) && (state_d == S_CHK_PD)) begin
        step_q <= step_q + 2'd1;
        mode_q <= seq_step(sel_q, step_q + 2'd1);
      end

      if (state_q == S_FIN) begin
        done_q <= 1'b1;
        if (abort_q) begin
          err_q      <= 1'b1;
          err_code_q <= ERR_TIMEOUT;
        end
      end
    end
  end

  assign rxeyeqreq_o  = (state_q == S_REQ) || (state_q == S_CAPT);
  assign rxeyeqmode_o = mode_q;
  assign busy_o       = (state_q != S_IDLE);
  assign step_o       = step_q;
  assign result_o     = result_q;
  assign result_vld_o = result_vld_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign err_code_o   = err_code_q;
  assign state_o      = state_q;

endmodule
